inst_encoder: RTL and testbench

Instruction encoder for the RV32I core: the inverse of the decode-side immediate extraction. It accepts an encode request (operation kind, register indices, funct3, 32-bit immediate) over a valid/ready handshake and emits fully packed 32-bit instructions on a second valid/ready stream. The pseudo-op LI expands into one or two instructions over consecutive beats. It feeds the debug/program-injection path that writes instruction words into IMEM or drives them directly into the fetch stage.

---
 rtl/inst_encoder_pkg.sv | 33 +++
 rtl/inst_pack.sv | 53 +++++
 rtl/inst_encoder.sv | 136 +++++++++++++
 tb/tb_inst_encoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: request op codes,
// major opcodes and the encoder FSM state type.
package inst_encoder_pkg;

    localparam logic [3:0] ENC_OP_LUI    = 4'd0;
    localparam logic [3:0] ENC_OP_AUIPC  = 4'd1;
    localparam logic [3:0] ENC_OP_JAL    = 4'd2;
    localparam logic [3:0] ENC_OP_JALR   = 4'd3;
    localparam logic [3:0] ENC_OP_BRANCH = 4'd4;
    localparam logic [3:0] ENC_OP_STORE  = 4'd5;
    localparam logic [3:0] ENC_OP_LOAD   = 4'd6;
    localparam logic [3:0] ENC_OP_ITYPE  = 4'd7;
    localparam logic [3:0] ENC_OP_CSRI   = 4'd8;
    localparam logic [3:0] ENC_OP_LI     = 4'd9;

    // Major opcodes, identical to the decode-side definitions.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOut  = 2'd1,
        StLiHi = 2'd2
    } enc_state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer. Range checking of the immediate exists only
// when INST_ENCODER_RANGE_CHECK_EN is defined; otherwise err is tied low.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);
`endif

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (op)
            ENC_OP_LUI:    word = {imm[31:12], rd, OPC_LUI};
            ENC_OP_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
            ENC_OP_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            ENC_OP_JALR:   word = {imm[11:0], rs1, funct3, rd, OPC_JALR};
            ENC_OP_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11],
                                   OPC_BRANCH};
            ENC_OP_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            ENC_OP_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            ENC_OP_ITYPE:  word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
            // CSR address is not carried by the request; zimm rides in rs1.
            ENC_OP_CSRI:   word = {12'b0, imm[4:0], funct3, rd, OPC_SYSTEM};
            default:       word = '0;
        endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
        case (op)
            ENC_OP_LUI, ENC_OP_AUIPC:                 err = |imm[11:0];
            ENC_OP_JAL:                               err = ~fits21 | imm[0];
            ENC_OP_BRANCH:                            err = ~fits13 | imm[0];
            ENC_OP_JALR, ENC_OP_STORE, ENC_OP_LOAD,
            ENC_OP_ITYPE:                             err = ~fits12;
            ENC_OP_CSRI:                              err = |imm[31:5];
            default:                                  err = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with valid/ready in and out; LI expands to LUI+ADDI.
// inst_err is only ever set when INST_ENCODER_RANGE_CHECK_EN is defined.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        inst_last,
    output logic        inst_err
);

    enc_state_e  state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [11:0] pend_lo_q, pend_lo_d;

    logic        li_short, li_split;
    logic [19:0] li_hi;
    logic [3:0]  p_op;
    logic [4:0]  p_rd, p_rs1, p_rs2;
    logic [2:0]  p_funct3;
    logic [31:0] p_imm, p_word;
    logic        p_err;

    // Rounding the upper part compensates for ADDI sign-extending the low 12 bits.
    assign li_short = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign li_hi    = req_imm[31:12] + {19'b0, req_imm[11]};
    assign li_split = (req_op == ENC_OP_LI) && !li_short && (req_imm[11:0] != 12'b0);

    always_comb begin
        p_op     = req_op;
        p_rd     = req_rd;
        p_rs1    = req_rs1;
        p_rs2    = req_rs2;
        p_funct3 = req_funct3;
        p_imm    = req_imm;
        if (state_q == StLiHi) begin
            p_op     = ENC_OP_ITYPE;
            p_rd     = pend_rd_q;
            p_rs1    = pend_rd_q;
            p_rs2    = 5'b0;
            p_funct3 = 3'b000;
            p_imm    = {{20{pend_lo_q[11]}}, pend_lo_q};
        end else if (req_op == ENC_OP_LI) begin
            p_rs1    = 5'b0;
            p_rs2    = 5'b0;
            p_funct3 = 3'b000;
            if (li_short) begin
                p_op = ENC_OP_ITYPE;
            end else begin
                p_op  = ENC_OP_LUI;
                p_imm = {li_hi, 12'b0};
            end
        end
    end

    inst_pack u_pack (
        .op     (p_op),
        .rd     (p_rd),
        .rs1    (p_rs1),
        .rs2    (p_rs2),
        .funct3 (p_funct3),
        .imm    (p_imm),
        .word   (p_word),
        .err    (p_err)
    );

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        last_d    = last_q;
        err_d     = err_q;
        pend_rd_d = pend_rd_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            StIdle:  req_ready = 1'b1;
            StOut:   req_ready = inst_ready;
            default: req_ready = 1'b0;
        endcase

        if (state_q == StLiHi) begin
            if (inst_ready) begin
                inst_d  = p_word;
                err_d   = 1'b0;
                last_d  = 1'b1;
                state_d = StOut;
            end
        end else if (req_valid && req_ready) begin
            inst_d    = p_word;
            err_d     = p_err;
            pend_rd_d = req_rd;
            pend_lo_d = req_imm[11:0];
            last_d    = !li_split;
            state_d   = li_split ? StLiHi : StOut;
        end else if (state_q == StOut && inst_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            inst_q    <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            pend_rd_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            last_q    <= last_d;
            err_q     <= err_d;
            pend_rd_q <= pend_rd_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign inst_valid = (state_q != StIdle);
    assign inst       = inst_q;
    assign inst_last  = last_q;
    assign inst_err   = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder; expected inst_err follows
// whether INST_ENCODER_RANGE_CHECK_EN is defined.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    localparam logic ChkEn = 1'b1;
`else
    localparam logic ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_imm;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic        inst_last, inst_err;

    int errors = 0;
    int checks = 0;

    inst_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_imm    (req_imm),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_last  (inst_last),
        .inst_err   (inst_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        req_valid  = 1'b1;
        req_op     = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_imm    = imm;
    endtask

    task automatic word(input string tag, input logic [31:0] w, input logic last,
                        input logic err);
        check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        check({tag, "_inst"}, inst, w);
        check({tag, "_last"}, {31'b0, inst_last}, {31'b0, last});
        check({tag, "_err"}, {31'b0, inst_err}, {31'b0, err});
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        inst_ready = 1'b1;
        drive(ENC_OP_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_last", {31'b0, inst_last}, 32'd0);
        check("rst_err", {31'b0, inst_err}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;
        step();

        // LI split into LUI + ADDI
        drive(ENC_OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        step();
        req_valid = 1'b0;
        word("li_lui", 32'h123462B7, 1'b0, 1'b0);
        check("li_hi_req_ready", {31'b0, req_ready}, 32'd0);
        step();
        word("li_addi", 32'hFFF28293, 1'b1, 1'b0);
        step();
        check("li_idle", {31'b0, inst_valid}, 32'd0);

        // Back-to-back JAL then BRANCH at full throughput
        drive(ENC_OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
        step();
        drive(ENC_OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
        check("out_req_ready", {31'b0, req_ready}, 32'd1);
        word("jal", 32'h001000EF, 1'b1, 1'b0);
        step();
        req_valid = 1'b0;
        word("branch", 32'hFE208EE3, 1'b1, 1'b0);
        step();

        drive(ENC_OP_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        step();
        req_valid = 1'b0;
        word("itype_range", 32'h80000093, 1'b1, ChkEn);
        step();

        drive(ENC_OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        step();
        req_valid = 1'b0;
        word("store", 32'h0020A423, 1'b1, 1'b0);
        step();

        drive(ENC_OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 32'h12345678);
        step();
        req_valid = 1'b0;
        word("lui_range", 32'h123450B7, 1'b1, ChkEn);
        step();

        drive(ENC_OP_CSRI, 5'd1, 5'd0, 5'd0, 3'd5, 32'd7);
        step();
        drive(ENC_OP_CSRI, 5'd1, 5'd0, 5'd0, 3'd5, 32'd40);
        word("csri_ok", 32'h0003D0F3, 1'b1, 1'b0);
        step();
        req_valid = 1'b0;
        word("csri_range", 32'h000450F3, 1'b1, ChkEn);
        step();

        // LI whose low part is zero: LUI only
        drive(ENC_OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00001000);
        step();
        req_valid = 1'b0;
        word("li_lui_only", 32'h000012B7, 1'b1, 1'b0);
        step();
        check("li_lui_only_idle", {31'b0, inst_valid}, 32'd0);

        // Back-pressure while the LUI half is held
        inst_ready = 1'b0;
        drive(ENC_OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            word("bp_lui", 32'h123462B7, 1'b0, 1'b0);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
            step();
        end
        inst_ready = 1'b1;
        step();
        word("bp_addi", 32'hFFF28293, 1'b1, 1'b0);
        step();
        check("bp_idle", {31'b0, inst_valid}, 32'd0);

        // Reset while LUI is pending
        inst_ready = 1'b0;
        drive(ENC_OP_LI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        step();
        req_valid = 1'b0;
        word("pre_rst_lui", 32'h123462B7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_last", {31'b0, inst_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        inst_ready = 1'b1;
        drive(ENC_OP_ITYPE, 5'd1, 5'd2, 5'd0, 3'd0, 32'd5);
        check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        word("post_rst_itype", 32'h00510093, 1'b1, 1'b0);
        step();
        check("post_rst_idle", {31'b0, inst_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
